// File: rtl/uart_pkg.sv
// Definitions shared by the UART line receiver and the TX data generator:
// line terminator codes and the line-buffer control state encoding.
package uart_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_HOLD  = 2'd2
   } line_state_t;

   function automatic logic is_term(input logic [7:0] b);
      return (b == ASCII_CR) || (b == ASCII_LF);
   endfunction

endpackage

// File: rtl/line_buf_ram.sv
// DEPTH x 8 simple dual-port line buffer: synchronous write port and a
// registered read port whose output register alone is cleared by reset.
module line_buf_ram #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [7:0]        i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [7:0]        o_rdata
);

   logic [7:0] r_mem [0:DEPTH-1];
   logic [7:0] r_rdata;

   localparam logic [31:0] DEPTH_U = DEPTH;

   // Storage has no reset so it maps onto plain distributed/DRM RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Addresses past the physical depth read as zero instead of indexing out of range.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= 8'h00;
      end else if (32'(i_raddr) < DEPTH_U) begin
         r_rdata <= r_mem[i_raddr];
      end else begin
         r_rdata <= 8'h00;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_line_rx.sv
// Collects received bytes into a line buffer until CR/LF or idle timeout,
// then holds the line for a consumer to read by address and acknowledge.
module uart_line_rx
   import uart_pkg::*;
#(
   parameter int DEPTH        = 32,
   parameter int ADDR_W       = 5,
   parameter int IDLE_TIMEOUT = 27_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              line_valid,
   output logic [7:0]        line_len,
   input  logic              line_ack,
   output logic              overflow,
   output logic              rx_drop
);

   localparam int          TMO_W    = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);
   localparam logic [7:0]  LEN_MAX  = 8'(DEPTH);

   line_state_t      r_state;
   logic [7:0]       r_len;
   logic [TMO_W-1:0] r_timer;
   logic             r_line_valid;
   logic             r_overflow;
   logic             r_rx_drop;

   logic              w_term;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;

   assign w_term  = is_term(rx_data);
   assign w_we    = rx_en && !w_term &&
                    ((r_state == ST_EMPTY) ||
                     ((r_state == ST_FILL) && (r_len < LEN_MAX)));
   assign w_waddr = (r_state == ST_EMPTY) ? '0 : r_len[ADDR_W-1:0];

   line_buf_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (rx_data),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_EMPTY;
         r_len        <= 8'd0;
         r_timer      <= '0;
         r_line_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_rx_drop    <= 1'b0;
      end else begin
         r_rx_drop <= (r_state == ST_HOLD) && rx_en;
         case (r_state)
            ST_EMPTY: begin
               r_timer <= '0;
               if (rx_en && !w_term) begin
                  r_len   <= 8'd1;
                  r_state <= ST_FILL;
               end
            end
            ST_FILL: begin
               // A byte on the timeout cycle wins and restarts the timer.
               if (rx_en) begin
                  r_timer <= '0;
                  if (w_term) begin
                     r_state      <= ST_HOLD;
                     r_line_valid <= 1'b1;
                  end else if (r_len < LEN_MAX) begin
                     r_len <= r_len + 8'd1;
                  end else begin
                     r_overflow <= 1'b1;
                  end
               end else if (r_timer == TMO_LAST) begin
                  r_timer      <= '0;
                  r_state      <= ST_HOLD;
                  r_line_valid <= 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_HOLD: begin
               r_timer <= '0;
               if (line_ack) begin
                  r_state      <= ST_EMPTY;
                  r_len        <= 8'd0;
                  r_overflow   <= 1'b0;
                  r_line_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_EMPTY;
               r_timer <= '0;
            end
         endcase
      end
   end

   assign line_valid = r_line_valid;
   assign line_len   = r_len;
   assign overflow   = r_overflow;
   assign rx_drop    = r_rx_drop;

endmodule

// File: tb/tb_uart_line_rx.sv
// Self-checking bench for uart_line_rx (DEPTH=4, IDLE_TIMEOUT=16): directed
// scenarios plus randomized traffic compared against a queue-based line model.
module tb_uart_line_rx;

   localparam int DEPTH = 4;
   localparam int ADDR_W = 2;
   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_en = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       line_valid;
   logic [7:0] line_len;
   logic       line_ack = 1'b0;
   logic       overflow;
   logic       rx_drop;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the line is a byte queue; timeout is measured from the
   // cycle number of the last accepted byte.
   logic [7:0] line_q[$];
   bit         m_held = 0;
   bit         m_ovf  = 0;
   bit         m_drop = 0;
   int         m_last = 0;
   int         cyc    = 0;
   logic [7:0] m_mem   [DEPTH];
   bit         m_known [DEPTH];
   logic [7:0] m_rd = 8'h00;
   bit         m_rd_known = 1;

   always #5 clk = ~clk;

   uart_line_rx #(
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W),
      .IDLE_TIMEOUT (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_en      (rx_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .line_valid (line_valid),
      .line_len   (line_len),
      .line_ack   (line_ack),
      .overflow   (overflow),
      .rx_drop    (rx_drop)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_push(input logic [7:0] b);
      int idx;
      idx = line_q.size();
      m_mem[idx]   = b;
      m_known[idx] = 1;
      line_q.push_back(b);
   endtask

   task automatic model_step(input logic en, input logic [7:0] d, input logic ack,
                             input logic [ADDR_W-1:0] addr, input logic r);
      bit term;
      term = (d == 8'h0D) || (d == 8'h0A);
      if (r) begin
         line_q.delete();
         m_held = 0;
         m_ovf = 0;
         m_drop = 0;
         m_rd = 8'h00;
         m_rd_known = 1;
      end else begin
         m_rd_known = m_known[addr];
         m_rd = m_mem[addr];
         m_drop = m_held && en;
         if (m_held) begin
            if (ack) begin
               m_held = 0;
               m_ovf = 0;
               line_q.delete();
            end
         end else if (line_q.size() == 0) begin
            if (en && !term) begin
               model_push(d);
               m_last = cyc;
            end
         end else if (en) begin
            m_last = cyc;
            if (term) m_held = 1;
            else if (line_q.size() < DEPTH) model_push(d);
            else m_ovf = 1;
         end else if (cyc - m_last >= TMO) begin
            m_held = 1;
         end
      end
   endtask

   task automatic tick(input logic en, input logic [7:0] d, input logic ack,
                       input logic [ADDR_W-1:0] addr, input logic r);
      @(negedge clk);
      rx_en = en;
      rx_data = d;
      line_ack = ack;
      rd_addr = addr;
      rst = r;
      @(posedge clk);
      cyc++;
      model_step(en, d, ack, addr, r);
      #1;
      check("line_valid", 32'(line_valid), 32'(m_held));
      check("line_len", 32'(line_len), 32'(line_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("rx_drop", 32'(rx_drop), 32'(m_drop));
      if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd));
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00, 1'b0, '0, 1'b0);
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      tick(1'b1, b, 1'b0, '0, 1'b0);
      idle(gap);
   endtask

   task automatic ack_line();
      tick(1'b0, 8'h00, 1'b1, '0, 1'b0);
   endtask

   task automatic read_at(input logic [ADDR_W-1:0] a, input logic [7:0] exp, input string tag);
      tick(1'b0, 8'h00, 1'b0, a, 1'b0);
      check(tag, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      logic [7:0] str6 [6];
      int en_thr;
      str6 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
      for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

      // Reset values
      tick(1'b0, 8'h00, 1'b0, '0, 1'b1);
      tick(1'b0, 8'h00, 1'b0, '0, 1'b1);
      check("reset_line_valid", 32'(line_valid), 32'd0);
      check("reset_line_len", 32'(line_len), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_rx_drop", 32'(rx_drop), 32'd0);
      check("reset_rd_data", 32'(rd_data), 32'd0);

      // "HI" CR at 10-cycle spacing
      send(8'h48, 9);
      send(8'h49, 9);
      tick(1'b1, 8'h0D, 1'b0, '0, 1'b0);
      check("hi_valid", 32'(line_valid), 32'd1);
      check("hi_len", 32'(line_len), 32'd2);
      read_at(2'd0, 8'h48, "hi_rd0");
      read_at(2'd1, 8'h49, "hi_rd1");

      // Byte during HOLD is dropped
      tick(1'b1, 8'h41, 1'b0, '0, 1'b0);
      check("hold_drop", 32'(rx_drop), 32'd1);
      check("hold_len", 32'(line_len), 32'd2);
      idle(1);
      check("hold_drop_end", 32'(rx_drop), 32'd0);
      ack_line();
      check("ack_valid", 32'(line_valid), 32'd0);
      send(8'h41, 2);
      tick(1'b1, 8'h0A, 1'b0, '0, 1'b0);
      check("a_len", 32'(line_len), 32'd1);
      read_at(2'd0, 8'h41, "a_rd0");
      ack_line();

      // Terminators on an empty buffer make no line
      send(8'h0D, 3);
      send(8'h0A, 3);
      send(8'h0D, 20);
      check("empty_term_valid", 32'(line_valid), 32'd0);
      check("empty_term_len", 32'(line_len), 32'd0);

      // Idle timeout exactly TMO edges after the last byte
      tick(1'b1, 8'h58, 1'b0, '0, 1'b0);
      for (int i = 1; i <= TMO; i++) begin
         idle(1);
         check("timeout_valid", 32'(line_valid), (i == TMO) ? 32'd1 : 32'd0);
      end
      check("timeout_len", 32'(line_len), 32'd1);
      ack_line();

      // Overflow with DEPTH=4
      for (int i = 0; i < 6; i++) send(str6[i], 1);
      tick(1'b1, 8'h0D, 1'b0, '0, 1'b0);
      check("ovf_len", 32'(line_len), 32'd4);
      check("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 0; i < DEPTH; i++) read_at(ADDR_W'(i), str6[i], "ovf_rd");
      ack_line();
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Reset mid-line
      send(8'h31, 1);
      send(8'h32, 1);
      send(8'h33, 1);
      tick(1'b0, 8'h00, 1'b0, '0, 1'b1);
      check("midrst_valid", 32'(line_valid), 32'd0);
      check("midrst_len", 32'(line_len), 32'd0);
      check("midrst_ovf", 32'(overflow), 32'd0);
      check("midrst_rd", 32'(rd_data), 32'd0);
      send(8'h5A, 1);
      tick(1'b1, 8'h0D, 1'b0, '0, 1'b0);
      check("z_len", 32'(line_len), 32'd1);
      ack_line();

      // Randomized traffic in phases of varying byte density
      en_thr = 1;
      for (int c = 0; c < 4000; c++) begin
         logic       en;
         logic [7:0] d;
         logic       ack;
         int         sel;
         if (c % 200 == 0) en_thr = $urandom_range(0, 3);
         en  = ($urandom_range(0, 7) < en_thr);
         sel = $urandom_range(0, 9);
         d   = (sel == 0) ? 8'h0D : (sel == 1) ? 8'h0A : 8'(8'h41 + $urandom_range(0, 25));
         ack = m_held ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
         tick(en, d, ack, ADDR_W'($urandom_range(0, DEPTH - 1)),
              ($urandom_range(0, 599) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
